// File: rtl/semaphore_arbiter.sv
// semaphore_arbiter: multi-core 1-bit semaphore bank with round-robin grant, one op per clock
//   CLK, RESET      : clock, async active-high reset
//   REQ_VALID[k]    : core k request, held until ACK[k]
//   REQ_OP[2k+:2]   : 00 read, 01 write, 10 test-and-set, 11 release
//   REQ_ADDR[..]    : per-core semaphore address, packed like REQ_OP
//   REQ_DATA[k]     : per-core write data
//   ACK/RDATA/ERR   : registered one-cycle completion, result and error per core
//   SEM_STATE       : current semaphore values
module semaphore_arbiter #(
    parameter int NumberOfCores      = 2,
    parameter int NumberOfSemaphores = 4,
    parameter int SemAddrWidth       = 2,
    parameter int OwnerWidth         = 1
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [NumberOfCores-1:0]              REQ_VALID,
    input  logic [2*NumberOfCores-1:0]            REQ_OP,
    input  logic [SemAddrWidth*NumberOfCores-1:0] REQ_ADDR,
    input  logic [NumberOfCores-1:0]              REQ_DATA,
    output logic [NumberOfCores-1:0]              ACK,
    output logic [NumberOfCores-1:0]              RDATA,
    output logic [NumberOfCores-1:0]              ERR,
    output logic [NumberOfSemaphores-1:0]         SEM_STATE
);
    logic [NumberOfSemaphores-1:0] value_q, value_d;
    logic [OwnerWidth-1:0]         owner_q [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         owner_d [NumberOfSemaphores];
    logic [OwnerWidth-1:0]         rr_q, rr_d;
    logic [NumberOfCores-1:0]      ack_q, ack_d, rdata_q, rdata_d, err_q, err_d;
    logic                          gnt, data, in_range, cur_v, wr, nv, set_own, rd, er;
    logic [1:0]                    op;
    logic [SemAddrWidth-1:0]       addr;
    logic [OwnerWidth-1:0]         g, cur_o;
    int                            idx, gidx;

    always_comb begin
        gnt     = 1'b0;
        gidx    = 0;
        idx     = 0;
        op      = '0;
        addr    = '0;
        data    = 1'b0;
        // Scan from the round-robin pointer; a core acked this cycle is masked so a held request is not served twice
        for (int i = 0; i < NumberOfCores; i++) begin
            idx = (int'(rr_q) + i >= NumberOfCores) ? int'(rr_q) + i - NumberOfCores : int'(rr_q) + i;
            if (!gnt && REQ_VALID[idx] && !ack_q[idx]) begin
                gnt  = 1'b1;
                gidx = idx;
                op   = REQ_OP[2*idx +: 2];
                addr = REQ_ADDR[SemAddrWidth*idx +: SemAddrWidth];
                data = REQ_DATA[idx];
            end
        end
        g        = OwnerWidth'(gidx);
        in_range = int'(addr) < NumberOfSemaphores;
        cur_v    = 1'b0;
        cur_o    = '0;
        for (int s = 0; s < NumberOfSemaphores; s++) begin
            if (int'(addr) == s) begin
                cur_v = value_q[s];
                cur_o = owner_q[s];
            end
        end
        wr      = 1'b0;
        nv      = 1'b0;
        set_own = 1'b0;
        rd      = 1'b0;
        er      = 1'b0;
        if (!in_range) begin
            er = 1'b1;
        end else begin
            case (op)
                2'b00: rd = cur_v;
                2'b01: begin
                    // Write may claim a free semaphore or update one the core already owns
                    wr      = !cur_v || cur_o == g;
                    nv      = data;
                    set_own = wr && data;
                    rd      = wr ? data : 1'b1;
                    er      = !wr;
                end
                2'b10: begin
                    rd      = cur_v;
                    wr      = !cur_v;
                    nv      = 1'b1;
                    set_own = !cur_v;
                end
                default: begin
                    wr = cur_v && cur_o == g;
                    nv = 1'b0;
                    rd = wr ? 1'b0 : cur_v;
                    er = !wr;
                end
            endcase
        end
        value_d = value_q;
        owner_d = owner_q;
        for (int s = 0; s < NumberOfSemaphores; s++) begin
            if (gnt && wr && int'(addr) == s) begin
                value_d[s] = nv;
                owner_d[s] = set_own ? g : owner_q[s];
            end
        end
        ack_d   = '0;
        rdata_d = '0;
        err_d   = '0;
        if (gnt) begin
            ack_d[gidx]   = 1'b1;
            rdata_d[gidx] = rd;
            err_d[gidx]   = er;
        end
        rr_d = !gnt ? rr_q : (gidx == NumberOfCores - 1) ? '0 : OwnerWidth'(gidx + 1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            value_q <= '0;
            owner_q <= '{default: '0};
            rr_q    <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            value_q <= value_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign SEM_STATE = value_q;
endmodule

// File: tb/tb_semaphore_arbiter.sv
// tb_semaphore_arbiter: directed checks of the semaphore bank with 4 cores and 3 semaphores
module tb_semaphore_arbiter;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, TS = 2'd2, RL = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid, req_data, ack, rdata, err;
    logic [7:0] req_op, req_addr;
    logic [2:0] sem;
    int         pass_cnt = 0;
    int         total    = 0;

    always #5 clk = ~clk;

    semaphore_arbiter #(
        .NumberOfCores(4), .NumberOfSemaphores(3), .SemAddrWidth(2), .OwnerWidth(2)
    ) dut (
        .CLK(clk), .RESET(rst), .REQ_VALID(req_valid), .REQ_OP(req_op),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .ACK(ack), .RDATA(rdata),
        .ERR(err), .SEM_STATE(sem)
    );

    task automatic set_req(input int k, input logic [1:0] op, input logic [1:0] a, input logic d);
        req_op[2*k +: 2]   = op;
        req_addr[2*k +: 2] = a;
        req_data[k]        = d;
    endtask

    // Issue one request from core k at a negedge and sample its result one cycle after the grant edge
    task automatic single_op(input int k, input logic [1:0] op, input logic [1:0] a, input logic d);
        @(negedge clk);
        set_req(k, op, a, d);
        req_valid    = '0;
        req_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_data = '0;
        repeat (2) @(negedge clk);
        total++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ack); else pass_cnt++;
        total++; if (sem !== 3'b000) $display("FAIL reset_sem: got %b want 000", sem); else pass_cnt++;
        total++; if ({rdata, err} !== 8'h00) $display("FAIL reset_rdata_err: got %b want 00000000", {rdata, err}); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ack !== 4'b0000) $display("FAIL idle_ack: got %b want 0000", ack); else pass_cnt++;
    endtask

    task automatic test_tas;
        single_op(0, TS, 2'd1, 1'b0);
        total++; if (ack !== 4'b0001) $display("FAIL tas_ack: got %b want 0001", ack); else pass_cnt++;
        total++; if ({rdata[0], err[0]} !== 2'b00) $display("FAIL tas_rdata_err: got %b want 00", {rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b010) $display("FAIL tas_sem: got %b want 010", sem); else pass_cnt++;
        @(negedge clk);
        total++; if (ack !== 4'b0000) $display("FAIL tas_ack_pulse: got %b want 0000", ack); else pass_cnt++;
        single_op(0, TS, 2'd1, 1'b0);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_10) $display("FAIL tas_again: got %b want 000110", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b010) $display("FAIL tas_again_sem: got %b want 010", sem); else pass_cnt++;
    endtask

    task automatic test_contention;
        single_op(3, RD, 2'd0, 1'b0);
        total++; if ({ack, rdata[3]} !== 5'b1000_0) $display("FAIL read3: got %b want 10000", {ack, rdata[3]}); else pass_cnt++;
        @(negedge clk);
        set_req(0, TS, 2'd2, 1'b0);
        set_req(1, TS, 2'd2, 1'b0);
        req_valid = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_00) $display("FAIL cont_win: got %b want 000100", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b110) $display("FAIL cont_sem: got %b want 110", sem); else pass_cnt++;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if ({ack, rdata[1], err[1]} !== 6'b0010_10) $display("FAIL cont_lose: got %b want 001010", {ack, rdata[1], err[1]}); else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_release;
        single_op(1, RL, 2'd2, 1'b0);
        total++; if ({ack, rdata[1], err[1]} !== 6'b0010_11) $display("FAIL rel_other: got %b want 001011", {ack, rdata[1], err[1]}); else pass_cnt++;
        total++; if (sem !== 3'b110) $display("FAIL rel_other_sem: got %b want 110", sem); else pass_cnt++;
        single_op(0, RL, 2'd2, 1'b0);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_00) $display("FAIL rel_owner: got %b want 000100", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b010) $display("FAIL rel_owner_sem: got %b want 010", sem); else pass_cnt++;
    endtask

    task automatic test_write;
        single_op(1, WR, 2'd1, 1'b0);
        total++; if ({ack, rdata[1], err[1]} !== 6'b0010_11) $display("FAIL wr_denied: got %b want 001011", {ack, rdata[1], err[1]}); else pass_cnt++;
        total++; if (sem !== 3'b010) $display("FAIL wr_denied_sem: got %b want 010", sem); else pass_cnt++;
        single_op(0, WR, 2'd1, 1'b0);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_00) $display("FAIL wr_owner: got %b want 000100", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b000) $display("FAIL wr_owner_sem: got %b want 000", sem); else pass_cnt++;
        single_op(2, WR, 2'd0, 1'b1);
        total++; if ({ack, rdata[2], err[2]} !== 6'b0100_10) $display("FAIL wr_free: got %b want 010010", {ack, rdata[2], err[2]}); else pass_cnt++;
        total++; if (sem !== 3'b001) $display("FAIL wr_free_sem: got %b want 001", sem); else pass_cnt++;
        single_op(3, RL, 2'd0, 1'b0);
        total++; if ({ack, rdata[3], err[3]} !== 6'b1000_11) $display("FAIL rel_nonowner: got %b want 100011", {ack, rdata[3], err[3]}); else pass_cnt++;
        total++; if (sem !== 3'b001) $display("FAIL rel_nonowner_sem: got %b want 001", sem); else pass_cnt++;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ack;
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_req(k, RD, 2'd0, 1'b0);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_ack = 4'b0001 << (c % 4);
            total++; if (ack !== exp_ack) $display("FAIL rr_ack%0d: got %b want %b", c, ack, exp_ack); else pass_cnt++;
            total++; if ({rdata, err} !== {exp_ack, 4'b0000}) $display("FAIL rr_data%0d: got %b want %b", c, {rdata, err}, {exp_ack, 4'b0000}); else pass_cnt++;
        end
        req_valid = '0;
        @(negedge clk);
        total++; if (ack !== 4'b0000) $display("FAIL rr_drain: got %b want 0000", ack); else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        single_op(0, TS, 2'd3, 1'b0);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_01) $display("FAIL oor_tas: got %b want 000101", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b001) $display("FAIL oor_tas_sem: got %b want 001", sem); else pass_cnt++;
        single_op(2, WR, 2'd3, 1'b1);
        total++; if ({ack, rdata[2], err[2]} !== 6'b0100_01) $display("FAIL oor_wr: got %b want 010001", {ack, rdata[2], err[2]}); else pass_cnt++;
        total++; if (sem !== 3'b001) $display("FAIL oor_wr_sem: got %b want 001", sem); else pass_cnt++;
    endtask

    task automatic test_reset_in_flight;
        @(negedge clk);
        set_req(1, TS, 2'd1, 1'b0);
        req_valid = 4'b0010;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (ack !== 4'b0000) $display("FAIL rif_ack: got %b want 0000", ack); else pass_cnt++;
        total++; if (sem !== 3'b000) $display("FAIL rif_sem: got %b want 000", sem); else pass_cnt++;
        total++; if ({rdata, err} !== 8'h00) $display("FAIL rif_rdata_err: got %b want 00000000", {rdata, err}); else pass_cnt++;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Cores 0 and 2 contend: a pointer left at 2 would pick core 2, a cleared one picks core 0
        set_req(0, TS, 2'd0, 1'b0);
        set_req(2, TS, 2'd0, 1'b0);
        req_valid = 4'b0101;
        @(posedge clk);
        @(negedge clk);
        total++; if ({ack, rdata[0], err[0]} !== 6'b0001_00) $display("FAIL rif_rr: got %b want 000100", {ack, rdata[0], err[0]}); else pass_cnt++;
        total++; if (sem !== 3'b001) $display("FAIL rif_rr_sem: got %b want 001", sem); else pass_cnt++;
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_tas;
        test_contention;
        test_release;
        test_write;
        test_round_robin;
        test_out_of_range;
        test_reset_in_flight;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
